tft_bus_arbiter: RTL and testbench
==================================

TFT_BUS_ARBITER -- requirements
Module: tft_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of TFT requesters; index 0 is the panel initialiser.
REQ-002 Parameter TIMEOUT, default 65535, maximum number of cycles a grant may be held without a transmit pulse.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (low = reset asserted).
REQ-005 start  in  1  level; high once maze and food generation are finished; arbitration is allowed only while high.
REQ-006 req  in  NUM_REQ  level request per requester; held high until that requester's TFT work is complete.
REQ-007 req_data  in  8*NUM_REQ  byte per requester; requester i occupies bits [8i+7:8i].
REQ-008 req_dc  in  NUM_REQ  data/command flag per requester.
REQ-009 req_transmit  in  NUM_REQ  single-cycle transmit strobe per requester.
REQ-010 tft_busy  in  1  SPI transmitter busy.
REQ-011 grant  out  NUM_REQ  registered one-hot-or-zero enable per requester.
REQ-012 spi_data  out  8, spi_dc  out  1, spi_transmit  out  1: muxed SPI inputs.
REQ-013 timeout_err  out  1  sticky flag; a grant was revoked by timeout.

Function
REQ-014 States: WAIT_START, INIT, ARB, HOLD, GAP.
REQ-015 WAIT_START: all grants 0; go to INIT when start=1 and req[0]=1.
REQ-016 INIT: grant[0]=1 on the first INIT cycle; no other requester is granted until INIT exits; exit to GAP when req[0]=0 and tft_busy=0.
REQ-017 ARB: if start=0, stay in ARB with grants 0; otherwise req[0] has fixed highest priority; else round-robin over req[NUM_REQ-1:1], search beginning one index after the last granted index, wrapping from NUM_REQ-1 to 1.
REQ-018 ARB with an eligible request: the grant bit is high on the next cycle (1-cycle latency), state goes to HOLD; with no request, stay in ARB.
REQ-019 HOLD: grant is held while req[g]=1 or tft_busy=1; when both are 0, grant drops on the next cycle and the state goes to GAP.
REQ-020 GAP: exactly one cycle with all grants 0, then ARB.
REQ-021 Round-robin pointer: updated to g on every grant of index >=1; reset value 0, so index 1 is searched first.
REQ-022 Mux: spi_data/spi_dc/spi_transmit equal the granted requester's signals; all three are 0 when no grant is high; combinational from the grant register.
REQ-023 Transmit strobes from non-granted requesters are discarded, never queued.
REQ-024 Timeout counter: cleared on grant and on each forwarded transmit; increments every HOLD/INIT cycle otherwise; saturates at TIMEOUT.
REQ-025 Counter reaching TIMEOUT while tft_busy=0: force release (grant 0 next cycle, go to GAP); set timeout_err=1.
REQ-026 Counter reaching TIMEOUT while tft_busy=1: release is deferred until tft_busy=0; a byte is never cut mid-transfer.
REQ-027 Simultaneous normal release and timeout in the same cycle: treated as a normal release; timeout_err is unchanged.
REQ-028 start falling during HOLD/INIT: the current grant completes normally; no new grant is issued until start=1.
REQ-029 At most one grant bit is high in any cycle.

Reset
REQ-030 Reset assertion asynchronously forces state to WAIT_START, grant to 0, pointer to 0, counter to 0, timeout_err to 0; spi_data, spi_dc and spi_transmit therefore read 0.
REQ-031 Reset mid-transfer: all outputs are 0 immediately; no completion of an in-flight grant is attempted.
REQ-032 Deassertion is taken synchronously to clk by the surrounding design; the block needs no internal synchroniser.

Structure
REQ-033 The state encoding and the TIMEOUT default belong in the shared TFT package, alongside the SPI command constants.
REQ-034 One sub-module, rr_pick: a combinational round-robin selector over NUM_REQ-1 requests plus a pointer, returning a one-hot index.
REQ-035 The top-level integration replaces its existing fixed-priority init/scene/player enable chain with this block.

Verification
REQ-036 start=1 and req=3'b111 after reset -> grant=001 until req[0] falls with tft_busy=0, then one GAP cycle with grant=000, then grant=010.
REQ-037 req[2:1]=11 held continuously after INIT -> grants alternate 010, 100, 010, each separated by exactly one cycle of 000.
REQ-038 Granted requester 1 idle with no transmit for TIMEOUT=16 cycles, tft_busy=0 -> grant drops on cycle 17, timeout_err=1, next grant is 100 if req[2]=1.
REQ-039 req_transmit[2]=1 while grant=010 -> spi_transmit stays 0; requester 1 strobe with data 8'hA5 -> spi_data=8'hA5, spi_transmit=1 in the same cycle.
REQ-040 rst pulled low mid-HOLD with tft_busy=1 -> grant=000, spi outputs 0 and timeout_err=0 before the next clk edge; after release the block waits in WAIT_START for start.

Source files
------------

// File: rtl/tft_bus_arbiter_pkg.sv
// Shared TFT definitions: arbiter state encoding, default grant timeout
// and the panel command bytes used by the SPI requesters.
package tft_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_START = 3'd0,
    ST_INIT       = 3'd1,
    ST_ARB        = 3'd2,
    ST_HOLD       = 3'd3,
    ST_GAP        = 3'd4
  } arb_state_e;

  localparam int TFT_TIMEOUT_DEF = 65535;

  localparam logic [7:0] SPI_CMD_SWRESET = 8'h01;
  localparam logic [7:0] SPI_CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] SPI_CMD_DISPON  = 8'h29;
  localparam logic [7:0] SPI_CMD_CASET   = 8'h2A;
  localparam logic [7:0] SPI_CMD_RASET   = 8'h2B;
  localparam logic [7:0] SPI_CMD_RAMWR   = 8'h2C;

endpackage

// File: rtl/tft_bus_arbiter_rr_pick.sv
// Round-robin selector: first request strictly after the last granted
// full index, wrapping to the lowest request; one-hot result.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic found;

  // Bit i stands for requester i+1; search above the pointer, then wrap
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i + 1 > int'(ptr_i))) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tft_bus_arbiter.sv
// TFT SPI bus arbiter: panel initialiser first, then fixed priority for
// index 0 and round-robin among the rest, with a hold timeout.
module tft_bus_arbiter
  import tft_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = TFT_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_dc,
  input  logic [NUM_REQ-1:0]     req_transmit,
  input  logic                   tft_busy,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             spi_data,
  output logic                   spi_dc,
  output logic                   spi_transmit,
  output logic                   timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_HIT = CW'(TIMEOUT - 1);

  arb_state_e           state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        pick_idx;
  logic [CW-1:0]        cnt_q;
  logic                 err_q;
  logic [NUM_REQ-2:0]   rr_gnt;
  logic                 held;
  logic                 rel_ok;
  logic                 to_hit;

  rr_pick #(
    .N  (NUM_REQ - 1),
    .PW (PW)
  ) u_rr_pick (
    .req_i (req[NUM_REQ-1:1]),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  // Steer the granted requester onto the SPI inputs; idle bus reads 0
  always_comb begin
    spi_data     = '0;
    spi_dc       = 1'b0;
    spi_transmit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        spi_data     = spi_data | req_data[8*i +: 8];
        spi_dc       = spi_dc | req_dc[i];
        spi_transmit = spi_transmit | req_transmit[i];
      end
    end
  end

  // Full requester index of the round-robin winner
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ - 1; i++) begin
      if (rr_gnt[i]) pick_idx = PW'(i + 1);
    end
  end

  // A byte in flight always blocks release; idle time excludes strobe cycles
  always_comb begin
    held   = |(req & grant_q);
    rel_ok = !held && !tft_busy;
    to_hit = !spi_transmit && (cnt_q >= CNT_HIT) && !tft_busy;
  end

  // Arbitration FSM with registered grant, pointer, counter and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_WAIT_START;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_WAIT_START: begin
          if (start && req[0]) begin
            state_q <= ST_INIT;
            grant_q <= NUM_REQ'(1);
            cnt_q   <= '0;
          end
        end
        ST_INIT, ST_HOLD: begin
          if (rel_ok || to_hit) begin
            state_q <= ST_GAP;
            grant_q <= '0;
            cnt_q   <= '0;
            if (!rel_ok) err_q <= 1'b1;
          end else if (spi_transmit) begin
            cnt_q <= '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_GAP, ST_ARB: begin
          state_q <= ST_ARB;
          if (start && req[0]) begin
            state_q <= ST_HOLD;
            grant_q <= NUM_REQ'(1);
            cnt_q   <= '0;
          end else if (start && (|rr_gnt)) begin
            state_q <= ST_HOLD;
            grant_q <= {rr_gnt, 1'b0};
            ptr_q   <= pick_idx;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_WAIT_START;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// Bench for tft_bus_arbiter: ownership model checked every cycle plus
// directed literal checks of the key sequences.
module tb_tft_bus_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  logic           clk      = 1'b0;
  logic           rst      = 1'b0;
  logic           start    = 1'b0;
  logic [N-1:0]   req      = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_dc   = '0;
  logic [N-1:0]   req_tx   = '0;
  logic           busy     = 1'b0;
  logic [N-1:0]   grant;
  logic [7:0]     spi_data;
  logic           spi_dc;
  logic           spi_tx;
  logic           terr;

  int n_chk  = 0;
  int n_fail = 0;
  int n;

  // Model: who owns the bus, how long idle, whether init has happened
  bit         m_own_v = 1'b0;
  logic [1:0] m_own   = '0;
  bit         m_init  = 1'b0;
  int         m_last  = 0;
  int         m_idle  = 0;
  bit         m_err   = 1'b0;

  always #5 clk = ~clk;

  tft_bus_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .req          (req),
    .req_data     (req_data),
    .req_dc       (req_dc),
    .req_transmit (req_tx),
    .tft_busy     (busy),
    .grant        (grant),
    .spi_data     (spi_data),
    .spi_dc       (spi_dc),
    .spi_transmit (spi_tx),
    .timeout_err  (terr)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] rr_cand(input int last, input int k);
    return 2'(((last - 1 + k) % (N - 1)) + 1);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_own_v = 1'b0;
      m_own   = '0;
      m_init  = 1'b0;
      m_last  = 0;
      m_idle  = 0;
      m_err   = 1'b0;
    end else if (m_own_v) begin
      if (req_tx[m_own]) m_idle = 0;
      else m_idle++;
      if (!req[m_own] && !busy) begin
        m_own_v = 1'b0;
      end else if (m_idle >= TO && !busy) begin
        m_own_v = 1'b0;
        m_err   = 1'b1;
      end
    end else if (!m_init) begin
      if (start && req[0]) begin
        m_own_v = 1'b1;
        m_own   = 2'd0;
        m_init  = 1'b1;
        m_idle  = 0;
      end
    end else if (start) begin
      if (req[0]) begin
        m_own_v = 1'b1;
        m_own   = 2'd0;
        m_idle  = 0;
      end else begin
        for (int k = 1; k < N; k++) begin
          if (!m_own_v && req[rr_cand(m_last, k)]) begin
            m_own_v = 1'b1;
            m_own   = rr_cand(m_last, k);
            m_last  = int'(m_own);
            m_idle  = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [N-1:0] eg;
    logic [7:0]   ed;
    logic         edc;
    logic         etx;
    eg  = m_own_v ? (N'(1) << m_own) : '0;
    ed  = m_own_v ? req_data[8*m_own +: 8] : 8'h00;
    edc = m_own_v ? req_dc[m_own] : 1'b0;
    etx = m_own_v ? req_tx[m_own] : 1'b0;
    chk("m_grant", grant, eg);
    chk("m_spi_data", spi_data, ed);
    chk("m_spi_dc", spi_dc, edc);
    chk("m_spi_tx", spi_tx, etx);
    chk("m_err", terr, m_err);
    chk("onehot0", $onehot0(grant), 1);
  end

  initial begin
    tick(2);
    chk("rst_grant", grant, 3'b000);
    chk("rst_err", terr, 0);
    chk("rst_spi", {spi_data, spi_dc, spi_tx}, 0);

    rst      = 1'b1;
    start    = 1'b1;
    req      = 3'b111;
    req_data = {8'h3C, 8'hA5, 8'h5A};
    req_dc   = 3'b100;
    tick(1);
    chk("init_grant", grant, 3'b001);
    tick(3);
    chk("init_hold", grant, 3'b001);
    req = 3'b110;
    tick(1);
    chk("init_gap", grant, 3'b000);
    tick(1);
    chk("first_rr", grant, 3'b010);

    tick(15);
    chk("to_hold16", grant, 3'b010);
    chk("to_err_pre", terr, 0);
    tick(1);
    chk("to_drop17", grant, 3'b000);
    chk("to_err", terr, 1);
    tick(1);
    chk("to_next", grant, 3'b100);

    n = 0;
    while (grant == 3'b100 && n < 40) begin
      tick(1);
      n++;
    end
    chk("alt_len", n, 16);
    chk("alt_gap", grant, 3'b000);
    tick(1);
    chk("alt_back", grant, 3'b010);

    req_tx = 3'b100;
    #1;
    chk("tx_other", spi_tx, 0);
    chk("tx_other_data", spi_data, 8'hA5);
    chk("tx_other_dc", spi_dc, 0);
    req_tx = 3'b010;
    #1;
    chk("tx_own", spi_tx, 1);
    chk("tx_own_data", spi_data, 8'hA5);
    tick(1);
    req_tx = '0;

    busy = 1'b1;
    tick(20);
    chk("defer_hold", grant, 3'b010);
    busy = 1'b0;
    tick(1);
    chk("defer_rel", grant, 3'b000);
    tick(1);
    chk("defer_next", grant, 3'b100);

    start = 1'b0;
    tick(1);
    req = 3'b010;
    tick(1);
    chk("stop_rel", grant, 3'b000);
    tick(5);
    chk("stop_idle", grant, 3'b000);
    start = 1'b1;
    tick(1);
    chk("restart", grant, 3'b010);

    busy = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    chk("arst_grant", grant, 3'b000);
    chk("arst_spi", {spi_data, spi_dc, spi_tx}, 0);
    chk("arst_err", terr, 0);
    start = 1'b0;
    req   = '0;
    busy  = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(3);
    chk("ws_idle", grant, 3'b000);
    start = 1'b1;
    req   = 3'b001;
    tick(1);
    chk("reinit", grant, 3'b001);
    tick(15);
    chk("init16", grant, 3'b001);
    req = 3'b000;
    tick(1);
    chk("both_rel", grant, 3'b000);
    chk("both_err", terr, 0);
    req = 3'b011;
    tick(1);
    chk("prio0", grant, 3'b001);
    req = 3'b010;
    tick(1);
    chk("prio_gap", grant, 3'b000);
    tick(1);
    chk("rr_ptr_rst", grant, 3'b010);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
